// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings for the memory access unit.
//   - access size encodings (byte/half/word; 2'd3 is illegal)
//   - FSM state encodings
//   - registered request struct
//   - helper returning (access bytes - 1) for the range check
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } mau_state_e;

  typedef struct packed {
    logic [31:0] addr;   // already truncated to the access alignment
    logic [1:0]  size;
    logic        sgn;
    logic        we;
    logic [31:0] wdata;
  } mau_req_t;

  // Offset of the last byte touched by an access of this size.
  function automatic logic [2:0] size_bytes_m1(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes_m1 = 3'd0;
      SZ_HALF: size_bytes_m1 = 3'd1;
      default: size_bytes_m1 = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_logic.sv
// mau_lane_logic: combinational byte-lane helper (little-endian lanes).
//   word_i   : memory word (read data or buffered word)
//   wdata_i  : right-aligned store data
//   lane_i   : byte offset within the word (addr[1:0])
//   size_i   : access size
//   sgn_i    : sign-extend loads when 1
//   ext_o    : extracted and extended load value
//   merged_o : word_i with the addressed lane(s) replaced by wdata_i
module mau_lane_logic
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign sh = {lane_i, 3'b000};

  always_comb begin
    shifted = word_i >> sh;
    ext_o   = word_i;
    mask    = '1;
    case (size_i)
      SZ_BYTE: begin
        ext_o = {{24{sgn_i & shifted[7]}}, shifted[7:0]};
        mask  = 32'h0000_00ff << sh;
      end
      SZ_HALF: begin
        ext_o = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
        mask  = 32'h0000_ffff << sh;
      end
      default: ;
    endcase
    // Word size: mask is all ones and sh is zero, so this yields wdata_i.
    merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for the word-addressed data memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready             : request handshake (ready only in IDLE)
//   req_we, req_size, req_signed    : store/load, size, load extension
//   req_addr, req_wdata             : byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_err: one-cycle completion pulse with data/error
//   mem_a, mem_we, mem_wd, mem_rd   : data_memory interface (combinational read)
//
// Build option: define MAU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors; otherwise low address bits are truncated to alignment.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 2064,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  mau_state_e  state_q, state_d;
  mau_req_t    req_q, req_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        size_bad, range_bad, acc_err;
  logic [32:0] end_addr;
  logic [31:0] addr_aligned;
  logic [31:0] lane_word, ext, merged;
  logic        wr_en;

  // Decode of the incoming request; 33-bit sum so a wrap past 2^32 still
  // counts as out of range.
  always_comb begin
    size_bad  = (req_size == 2'd3);
    end_addr  = {1'b0, req_addr} + {30'd0, size_bytes_m1(req_size)};
    range_bad = (end_addr >= 33'(MEM_BYTES));
    addr_aligned = req_addr;
    if (req_size == SZ_HALF)      addr_aligned[0]   = 1'b0;
    else if (req_size == SZ_WORD) addr_aligned[1:0] = 2'b00;
`ifdef MAU_MISALIGN_TRAP_EN
    acc_err = size_bad | range_bad |
              ((req_size == SZ_HALF) && req_addr[0]) |
              ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    acc_err = size_bad | range_bad;
`endif
  end

  // Extraction works on live read data; merging works on the buffered word.
  assign lane_word = (state_q == ST_WR) ? word_buf_q : mem_rd;

  mau_lane_logic u_lane (
    .word_i   (lane_word),
    .wdata_i  (req_q.wdata),
    .lane_i   (req_q.addr[1:0]),
    .size_i   (req_q.size),
    .sgn_i    (req_q.sgn),
    .ext_o    (ext),
    .merged_o (merged)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    word_buf_d = word_buf_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_a      = '0;
    mem_wd     = '0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.addr  = addr_aligned;
          req_d.size  = req_size;
          req_d.sgn   = req_signed;
          req_d.we    = req_we;
          req_d.wdata = req_wdata;
          err_d       = acc_err;
          rdata_d     = acc_err ? RESET_RDATA : '0;
          if (acc_err)                            state_d = ST_RESP;
          else if (!req_we || req_size != SZ_WORD) state_d = ST_RD;
          else                                    state_d = ST_WR;
        end
      end
      ST_RD: begin
        mem_a      = {req_q.addr[31:2], 2'b00};
        word_buf_d = mem_rd;
        if (!req_q.we) begin
          rdata_d = ext;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        mem_a   = {req_q.addr[31:2], 2'b00};
        wr_en   = 1'b1;
        mem_wd  = (req_q.size == SZ_WORD) ? req_q.wdata : merged;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      word_buf_q <= '0;
      rdata_q    <= RESET_RDATA;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      word_buf_q <= word_buf_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  // Reset is synchronous, so the FSM can still sit in WR during a reset cycle.
  assign mem_we     = wr_en & ~reset;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Data memory model: combinational read, write on posedge.
  logic [31:0] mem [0:515];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int          cyc = 0;

  assign mem_rd = (mem_a < 32'd2064) ? mem[mem_a[11:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we && mem_a < 32'd2064) mem[mem_a[11:2]] <= mem_wd;
    if (poke_en) mem[poke_idx] <= poke_val;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor / scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      wr_cnt++;
      last_wa = mem_a;
      last_wd = mem_wd;
    end
    if (resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx[9:0]; poke_val = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input bit expect_resp, input bit hold, output int acc_cyc);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    if (expect_resp) begin
      e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, wc;
    int acc[4];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);

    poke(0, 32'hAABBCCDD);
    poke(1, 32'h11223344);
    poke(2, 32'h80FF7F01);
    poke(3, 32'hCAFEF00D);
    poke(515, 32'h5A000000);
    for (int i = 0; i < 4; i++) poke(8 + i, 32'h1000_0000 + i * 32'h0101);
    @(negedge clk);
    reset = 1'b0;

    // Byte store RMW into a preset word.
    issue(1, SZ_BYTE, 0, 32'd5, 32'h000000AB, 32'h0, 0, 3, 1, 0, a0);
    drain();
    chk("sb_mem_word", mem[1], 32'h1122AB44);
    chk("sb_wr_addr", last_wa, 32'd4);
    chk("sb_wr_data", last_wd, 32'h1122AB44);

    // Sub-word loads with both extensions.
    issue(0, SZ_BYTE, 1, 32'd10, 32'h0, 32'hFFFFFFFF, 0, 2, 1, 0, a0);
    issue(0, SZ_BYTE, 0, 32'd8,  32'h0, 32'h00000001, 0, 2, 1, 0, a0);
    issue(0, SZ_HALF, 1, 32'd10, 32'h0, 32'hFFFF80FF, 0, 2, 1, 0, a0);
    issue(0, SZ_HALF, 0, 32'd8,  32'h0, 32'h00007F01, 0, 2, 1, 0, a0);
    drain();

    // Misaligned word load.
    wc = wr_cnt;
`ifdef MAU_MISALIGN_TRAP_EN
    issue(0, SZ_WORD, 0, 32'd6, 32'h0, 32'h0, 1, 1, 1, 0, a0);
`else
    issue(0, SZ_WORD, 0, 32'd6, 32'h0, 32'h1122AB44, 0, 2, 1, 0, a0);
`endif
    drain();
    chk("misal_no_write", wr_cnt, wc);

    // Error cases and the last legal byte.
    issue(1, SZ_WORD, 0, 32'd2064, 32'h12345678, 32'h0, 1, 1, 1, 0, a0);
    issue(1, 2'd3, 0, 32'd0, 32'h12345678, 32'h0, 1, 1, 1, 0, a0);
    issue(1, SZ_HALF, 0, 32'd2063, 32'h0000BEEF, 32'h0, 1, 1, 1, 0, a0);
    issue(0, SZ_BYTE, 0, 32'd2063, 32'h0, 32'h0000005A, 0, 2, 1, 0, a0);
    drain();
    chk("err_no_write", wr_cnt, wc);
    chk("err_mem0_intact", mem[0], 32'hAABBCCDD);

    // Half store into the upper lanes, then a plain word store.
    issue(1, SZ_HALF, 0, 32'd2, 32'h00001234, 32'h0, 0, 3, 1, 0, a0);
    issue(1, SZ_WORD, 0, 32'd16, 32'h01020304, 32'h0, 0, 2, 1, 0, a0);
    drain();
    chk("sh_mem_word", mem[0], 32'h1234CCDD);
    chk("sw_mem_word", mem[4], 32'h01020304);

    // Reset asserted during the WR cycle of a byte store.
    wc = wr_cnt;
    issue(1, SZ_BYTE, 0, 32'd13, 32'h00000077, 32'h0, 0, 0, 0, 0, a0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_wr_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_wr_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_wr_mem_word", mem[3], 32'hCAFEF00D);
    chk("rst_wr_no_write", wr_cnt, wc);

    // Four word loads with req_valid held high.
    for (int i = 0; i < 4; i++)
      issue(0, SZ_WORD, 0, 32'd32 + 32'(i * 4), 32'h0, 32'h1000_0000 + 32'(i) * 32'h0101,
            0, 2, 1, (i < 3), acc[i]);
    drain();
    for (int i = 1; i < 4; i++) begin
      a1 = acc[i] - acc[i-1];
      chk("b2b_interval", a1, 32'd3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
